// File: rtl/minesweeper_pkg.sv
// Shared types for the minesweeper cell array: cell state encoding, neighbour
// limits and the default neighbour-count width.
package minesweeper_pkg;

  localparam int MAX_NEIGHBOURS = 8;

  typedef enum logic [2:0] {
    HIDDEN   = 3'd0,
    FLAGGED  = 3'd1,
    QUESTION = 3'd2,
    REVEALED = 3'd3,
    EXPLODED = 3'd4
  } cell_state_t;

  // Wide enough to hold n itself, so a fully set neighbour vector cannot wrap.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/nbr_popcount.sv
// Population count of a neighbour bit vector.
module nbr_popcount #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic [N-1:0]     bits_i,
  output logic [CNT_W-1:0] count_o
);

  // NOTE: blocking assignments here are intentional; the loop accumulates a
  // running sum inside one combinational evaluation.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < N; i++) begin
      count_o = count_o + CNT_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/mine_cell_gen.sv
// One minesweeper board cell: user click/flag/chord handling, zero cascade and
// end-of-game reveal. Define MINE_CELL_QUESTION_EN to add the '?' flag state.
module mine_cell_gen
  import minesweeper_pkg::*;
#(
  parameter int NEIGHBOURS = MAX_NEIGHBOURS,
  parameter int CNT_W      = cnt_width(NEIGHBOURS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  playing,
  input  logic                  init_mine,
  input  logic                  user_click,
  input  logic                  user_flag,
  input  logic                  user_chord,
  input  logic [NEIGHBOURS-1:0] mines_around,
  input  logic [NEIGHBOURS-1:0] zero_around,
  input  logic [NEIGHBOURS-1:0] flagged_around,
  input  logic [NEIGHBOURS-1:0] chord_around,
  output cell_state_t           state,
  output logic [CNT_W-1:0]      mines_beside,
  output logic                  is_zero,
  output logic                  chord_out,
  output logic                  block_won,
  output logic                  block_lost
);

  cell_state_t      state_q;
  logic             chord_out_q;
  logic             click_q, flag_q, chord_q, playing_q;
  logic [CNT_W-1:0] flags_beside;
  logic             click_edge, flag_edge, chord_edge;
  logic             hit, cascade, playing_fall;

  nbr_popcount #(.N(NEIGHBOURS), .CNT_W(CNT_W)) u_mine_cnt (
    .bits_i  (mines_around),
    .count_o (mines_beside)
  );

  nbr_popcount #(.N(NEIGHBOURS), .CNT_W(CNT_W)) u_flag_cnt (
    .bits_i  (flagged_around),
    .count_o (flags_beside)
  );

  // User and neighbour stimuli only count while a game is in progress.
  assign click_edge   = playing & user_click & ~click_q;
  assign flag_edge    = playing & user_flag  & ~flag_q;
  assign chord_edge   = playing & user_chord & ~chord_q;
  assign hit          = click_edge | (playing & (|chord_around));
  assign cascade      = playing & (|zero_around);
  assign playing_fall = playing_q & ~playing;

  // NOTE: reset is synchronous and active-low; it sits inside the clocked
  // block and overrides every other update in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= HIDDEN;
      chord_out_q <= 1'b0;
      click_q     <= 1'b0;
      flag_q      <= 1'b0;
      chord_q     <= 1'b0;
      playing_q   <= 1'b0;
    end else begin
      click_q     <= user_click;
      flag_q      <= user_flag;
      chord_q     <= user_chord;
      playing_q   <= playing;
      chord_out_q <= 1'b0;
      unique case (state_q)
        HIDDEN, QUESTION: begin
          if (hit)                           state_q <= init_mine ? EXPLODED : REVEALED;
          else if (cascade)                  state_q <= REVEALED;
          else if (playing_fall && init_mine) state_q <= REVEALED;
          else if (flag_edge)                state_q <= (state_q == HIDDEN) ? FLAGGED : HIDDEN;
        end
        FLAGGED: begin
          if (playing_fall && init_mine) state_q <= REVEALED;
          else if (flag_edge) begin
`ifdef MINE_CELL_QUESTION_EN
            state_q <= QUESTION;
`else
            state_q <= HIDDEN;
`endif
          end
        end
        REVEALED: begin
          if (chord_edge && (flags_beside == mines_beside)) chord_out_q <= 1'b1;
        end
        EXPLODED: ;
        default: state_q <= HIDDEN;
      endcase
    end
  end

  assign state      = state_q;
  assign chord_out  = chord_out_q;
  assign is_zero    = (state_q == REVEALED) & ~init_mine & (mines_beside == '0);
  assign block_lost = (state_q == EXPLODED);
  assign block_won  = (~init_mine & (state_q == REVEALED)) | (init_mine & (state_q != EXPLODED));

endmodule

// File: tb/tb_mine_cell_gen.sv
// Self-checking bench for mine_cell_gen (NEIGHBOURS=8); registered outputs are
// scored against a queue of expectations pushed as stimulus is applied.
module tb_mine_cell_gen;
  import minesweeper_pkg::*;

  localparam int N = 8;
  localparam int W = cnt_width(N);

  logic clk = 1'b0;
  logic reset, playing, init_mine, user_click, user_flag, user_chord;
  logic [N-1:0] mines_around, zero_around, flagged_around, chord_around;
  cell_state_t  state;
  logic [W-1:0] mines_beside;
  logic is_zero, chord_out, block_won, block_lost;

  typedef struct {
    string       tag;
    cell_state_t st;
    logic        chord;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_run  = 0;
  int n_fail = 0;

  mine_cell_gen #(.NEIGHBOURS(N)) dut (
    .clk(clk), .reset(reset), .playing(playing), .init_mine(init_mine),
    .user_click(user_click), .user_flag(user_flag), .user_chord(user_chord),
    .mines_around(mines_around), .zero_around(zero_around),
    .flagged_around(flagged_around), .chord_around(chord_around),
    .state(state), .mines_beside(mines_beside), .is_zero(is_zero),
    .chord_out(chord_out), .block_won(block_won), .block_lost(block_lost)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    playing = 0; init_mine = 0; user_click = 0; user_flag = 0; user_chord = 0;
    mines_around = '0; zero_around = '0; flagged_around = '0; chord_around = '0;
  endtask

  task automatic do_reset();
    reset = 0;
    clear_inputs();
    cycle();
    cycle();
    reset = 1;
  endtask

  task automatic test_reset();
    reset = 0;
    clear_inputs();
    user_click = 1;
    zero_around = 8'hFF;
    sb.push_back('{"reset_state", HIDDEN, 1'b0});
    cycle();
    e = sb.pop_front();
    n_run++;
    if (state !== e.st || chord_out !== e.chord) begin
      n_fail++;
      $display("FAIL %s: state=%0d chord_out=%b, want %0d/%b", e.tag, state, chord_out, e.st, e.chord);
    end
    n_run++;
    if ({block_lost, block_won, is_zero, mines_beside} !== {1'b0, 1'b0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_flags: lost/won/zero/beside=%b%b%b/%0d, want 000/0", block_lost, block_won, is_zero, mines_beside);
    end
    do_reset();
  endtask

  task automatic test_click_reveal();
    do_reset();
    playing = 1;
    mines_around = 8'h05;
    #1;
    n_run++;
    if (mines_beside !== 4'd2) begin
      n_fail++; $display("FAIL popcount_05: mines_beside=%0d, want 2", mines_beside);
    end
    user_click = 1;
    sb.push_back('{"click_reveal", REVEALED, 1'b0});
    cycle();
    e = sb.pop_front();
    n_run++;
    if (state !== e.st || chord_out !== e.chord) begin
      n_fail++;
      $display("FAIL %s: state=%0d chord_out=%b, want %0d/%b", e.tag, state, chord_out, e.st, e.chord);
    end
    n_run++;
    if (is_zero !== 1'b0 || block_won !== 1'b1 || block_lost !== 1'b0) begin
      n_fail++; $display("FAIL reveal_flags: is_zero=%b won=%b lost=%b, want 0/1/0", is_zero, block_won, block_lost);
    end
    mines_around = 8'h00;
    #1;
    n_run++;
    if (is_zero !== 1'b1) begin
      n_fail++; $display("FAIL is_zero_empty: is_zero=%b, want 1", is_zero);
    end
    mines_around = 8'hFF;
    #1;
    n_run++;
    if (mines_beside !== 4'd8 || is_zero !== 1'b0) begin
      n_fail++; $display("FAIL popcount_full: mines_beside=%0d is_zero=%b, want 8/0", mines_beside, is_zero);
    end
  endtask

  task automatic test_mine();
    do_reset();
    init_mine = 1;
    playing = 1;
    cycle();
    user_click = 1;
    sb.push_back('{"mine_explode", EXPLODED, 1'b0});
    cycle();
    e = sb.pop_front();
    n_run++;
    if (state !== e.st || block_lost !== 1'b1 || block_won !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: state=%0d lost=%b won=%b, want %0d/1/0", e.tag, state, block_lost, block_won, e.st);
    end
    playing = 0;
    user_click = 0;
    sb.push_back('{"explode_absorb", EXPLODED, 1'b0});
    cycle();
    e = sb.pop_front();
    n_run++;
    if (state !== e.st) begin
      n_fail++; $display("FAIL %s: state=%0d, want %0d", e.tag, state, e.st);
    end
    // Untouched mine cell is shown when the game ends; a plain cell holds.
    do_reset();
    init_mine = 1;
    playing = 1;
    cycle();
    playing = 0;
    sb.push_back('{"end_reveal_mine", REVEALED, 1'b0});
    cycle();
    e = sb.pop_front();
    n_run++;
    if (state !== e.st || block_won !== 1'b1) begin
      n_fail++; $display("FAIL %s: state=%0d won=%b, want %0d/1", e.tag, state, block_won, e.st);
    end
    do_reset();
    playing = 1;
    cycle();
    playing = 0;
    sb.push_back('{"end_hold_plain", HIDDEN, 1'b0});
    cycle();
    e = sb.pop_front();
    n_run++;
    if (state !== e.st) begin
      n_fail++; $display("FAIL %s: state=%0d, want %0d", e.tag, state, e.st);
    end
  endtask

  task automatic test_cascade();
    do_reset();
    zero_around = 8'h10;
    sb.push_back('{"cascade_idle", HIDDEN, 1'b0});
    cycle();
    e = sb.pop_front();
    n_run++;
    if (state !== e.st) begin
      n_fail++; $display("FAIL %s: state=%0d, want %0d", e.tag, state, e.st);
    end
    playing = 1;
    sb.push_back('{"cascade_reveal", REVEALED, 1'b0});
    cycle();
    e = sb.pop_front();
    n_run++;
    if (state !== e.st) begin
      n_fail++; $display("FAIL %s: state=%0d, want %0d", e.tag, state, e.st);
    end
    do_reset();
    playing = 1;
    user_flag = 1;
    cycle();
    user_flag = 0;
    zero_around = 8'h10;
    sb.push_back('{"cascade_flagged", FLAGGED, 1'b0});
    cycle();
    cycle();
    e = sb.pop_front();
    n_run++;
    if (state !== e.st) begin
      n_fail++; $display("FAIL %s: state=%0d, want %0d", e.tag, state, e.st);
    end
  endtask

  task automatic test_chord();
    do_reset();
    playing = 1;
    mines_around = 8'h01;
    user_click = 1;
    cycle();
    user_click = 0;
    flagged_around = 8'h01;
    user_chord = 1;
    sb.push_back('{"chord_pulse", REVEALED, 1'b1});
    sb.push_back('{"chord_one_cycle", REVEALED, 1'b0});
    for (int i = 0; i < 2; i++) begin
      cycle();
      e = sb.pop_front();
      n_run++;
      if (state !== e.st || chord_out !== e.chord) begin
        n_fail++;
        $display("FAIL %s: state=%0d chord_out=%b, want %0d/%b", e.tag, state, chord_out, e.st, e.chord);
      end
    end
    user_chord = 0;
    cycle();
    flagged_around = 8'h00;
    user_chord = 1;
    sb.push_back('{"chord_mismatch", REVEALED, 1'b0});
    cycle();
    e = sb.pop_front();
    n_run++;
    if (state !== e.st || chord_out !== e.chord) begin
      n_fail++;
      $display("FAIL %s: state=%0d chord_out=%b, want %0d/%b", e.tag, state, chord_out, e.st, e.chord);
    end
    do_reset();
    playing = 1;
    chord_around = 8'h02;
    sb.push_back('{"chord_in_hidden", REVEALED, 1'b0});
    cycle();
    e = sb.pop_front();
    n_run++;
    if (state !== e.st) begin
      n_fail++; $display("FAIL %s: state=%0d, want %0d", e.tag, state, e.st);
    end
    do_reset();
    playing = 1;
    user_flag = 1;
    cycle();
    user_flag = 0;
    chord_around = 8'h02;
    sb.push_back('{"chord_in_flagged", FLAGGED, 1'b0});
    cycle();
    e = sb.pop_front();
    n_run++;
    if (state !== e.st) begin
      n_fail++; $display("FAIL %s: state=%0d, want %0d", e.tag, state, e.st);
    end
  endtask

  task automatic test_flag_cycle();
    cell_state_t model;
    int rises;
`ifdef MINE_CELL_QUESTION_EN
    rises = 3;
`else
    rises = 2;
`endif
    do_reset();
    playing = 1;
    model = HIDDEN;
    for (int r = 0; r < rises; r++) begin
      case (model)
        HIDDEN:   model = FLAGGED;
`ifdef MINE_CELL_QUESTION_EN
        FLAGGED:  model = QUESTION;
`else
        FLAGGED:  model = HIDDEN;
`endif
        default:  model = HIDDEN;
      endcase
      user_flag = 1;
      for (int h = 0; h < 5; h++) begin
        sb.push_back('{$sformatf("flag_rise%0d_hold%0d", r, h), model, 1'b0});
        cycle();
        e = sb.pop_front();
        n_run++;
        if (state !== e.st) begin
          n_fail++; $display("FAIL %s: state=%0d, want %0d", e.tag, state, e.st);
        end
      end
      user_flag = 0;
      cycle();
    end
    n_run++;
    if (state !== HIDDEN) begin
      n_fail++; $display("FAIL flag_cycle_home: state=%0d, want %0d", state, HIDDEN);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    playing = 1;
    user_click = 1;
    user_flag = 1;
    sb.push_back('{"click_beats_flag", REVEALED, 1'b0});
    cycle();
    e = sb.pop_front();
    n_run++;
    if (state !== e.st) begin
      n_fail++; $display("FAIL %s: state=%0d, want %0d", e.tag, state, e.st);
    end
    do_reset();
    playing = 1;
    cycle();
    zero_around = 8'h01;
    reset = 0;
    sb.push_back('{"reset_mid_cascade", HIDDEN, 1'b0});
    cycle();
    e = sb.pop_front();
    n_run++;
    if (state !== e.st || chord_out !== e.chord) begin
      n_fail++;
      $display("FAIL %s: state=%0d chord_out=%b, want %0d/%b", e.tag, state, chord_out, e.st, e.chord);
    end
    reset = 1;
    zero_around = 8'h00;
    mines_around = 8'h01;
    user_click = 1;
    cycle();
    user_click = 0;
    flagged_around = 8'h01;
    user_chord = 1;
    reset = 0;
    sb.push_back('{"reset_mid_chord", HIDDEN, 1'b0});
    cycle();
    e = sb.pop_front();
    n_run++;
    if (state !== e.st || chord_out !== e.chord) begin
      n_fail++;
      $display("FAIL %s: state=%0d chord_out=%b, want %0d/%b", e.tag, state, chord_out, e.st, e.chord);
    end
    reset = 1;
  endtask

  initial begin
    reset = 0;
    clear_inputs();
    test_reset();
    test_click_reveal();
    test_mine();
    test_cascade();
    test_chord();
    test_flag_cycle();
    test_back_to_back();
    if (sb.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
